// File: rtl/commit_checker_if.sv
// rtl/commit_checker_if.sv - bundled load, commit-event and status signals for commit_checker
// master drives loads and retired events; slave is the checker.
interface commit_checker_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int MEM_AW = 32,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(3 * DEPTH + 1);

  logic              clear;
  logic              exp_valid;
  logic              exp_ready;
  logic [1:0]        exp_chan;
  logic [MEM_AW-1:0] exp_addr;
  logic [DATA_W-1:0] exp_data;
  logic              start;
  logic              wb_en;
  logic [REG_AW-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              br_taken;
  logic [MEM_AW-1:0] br_target;
  logic              done;
  logic              pass;
  logic              fail;
  logic [2:0]        err_code;
  logic [1:0]        err_chan;
  logic [DATA_W-1:0] err_exp;
  logic [DATA_W-1:0] err_act;
  logic [CNT_W-1:0]  match_cnt;

  modport master (
    output clear, exp_valid, exp_chan, exp_addr, exp_data, start,
           wb_en, wb_addr, wb_data, mem_we, mem_waddr, mem_wdata, br_taken, br_target,
    input  exp_ready, done, pass, fail, err_code, err_chan, err_exp, err_act, match_cnt
  );

  modport slave (
    input  clear, exp_valid, exp_chan, exp_addr, exp_data, start,
           wb_en, wb_addr, wb_data, mem_we, mem_waddr, mem_wdata, br_taken, br_target,
    output exp_ready, done, pass, fail, err_code, err_chan, err_exp, err_act, match_cnt
  );
endinterface

// File: rtl/commit_checker.sv
// rtl/commit_checker.sv - in-order commit-stream checker against preloaded expected-event queues
// REG/MEM/BR queues are filled in IDLE and consumed head-first while RUN.
module commit_checker #(
  parameter int DATA_W  = 32,
  parameter int REG_AW  = 5,
  parameter int MEM_AW  = 32,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 500
) (
  input logic             i_clk,
  input logic             i_rst,
  commit_checker_if.slave io_bus
);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int QCW   = $clog2(DEPTH + 1);
  localparam int CNT_W = $clog2(3 * DEPTH + 1);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int NCH   = 3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  localparam logic [2:0] E_NONE     = 3'd0;
  localparam logic [2:0] E_MISMATCH = 3'd1;
  localparam logic [2:0] E_UNEXP    = 3'd2;
  localparam logic [2:0] E_TIMEOUT  = 3'd3;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [MEM_AW-1:0] r_q_addr [NCH][DEPTH];
  logic [DATA_W-1:0] r_q_data [NCH][DEPTH];
  logic [PW-1:0]     r_wp     [NCH];
  logic [PW-1:0]     r_rp     [NCH];
  logic [QCW-1:0]    r_cnt    [NCH];
  logic [TW-1:0]     r_timer;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [2:0]        r_err_code;
  logic [1:0]        r_err_chan;
  logic [DATA_W-1:0] r_err_exp;
  logic [DATA_W-1:0] r_err_act;

  logic              w_flush;
  logic              w_push;
  logic              w_sel_full;
  logic [NCH-1:0]    w_ev;
  logic [NCH-1:0]    w_hit;
  logic [NCH-1:0]    w_unexp;
  logic [NCH-1:0]    w_mism;
  logic [NCH-1:0]    w_pop;
  logic [NCH-1:0]    w_left;
  logic              w_err_any;
  logic              w_all_empty;
  logic [MEM_AW-1:0] w_act_addr  [NCH];
  logic [DATA_W-1:0] w_act_data  [NCH];
  logic [MEM_AW-1:0] w_head_addr [NCH];
  logic [DATA_W-1:0] w_head_data [NCH];
  logic [2:0]        w_err_code;
  logic [1:0]        w_err_chan;
  logic [DATA_W-1:0] w_err_exp;
  logic [DATA_W-1:0] w_err_act;
  logic              w_lat_err;
  logic [2:0]        w_nxt_code;
  logic [1:0]        w_nxt_chan;
  logic [DATA_W-1:0] w_nxt_exp;
  logic [DATA_W-1:0] w_nxt_act;

  assign w_flush = i_rst || io_bus.clear;

  always_comb begin
    w_sel_full = 1'b1;
    case (io_bus.exp_chan)
      2'd0:    w_sel_full = (r_cnt[0] == QCW'(DEPTH));
      2'd1:    w_sel_full = (r_cnt[1] == QCW'(DEPTH));
      2'd2:    w_sel_full = (r_cnt[2] == QCW'(DEPTH));
      default: w_sel_full = 1'b1;
    endcase
  end

  assign io_bus.exp_ready = (r_state == S_IDLE) && !w_sel_full;
  assign w_push           = io_bus.exp_valid && io_bus.exp_ready;

  // Map every channel onto a common {addr,data} compare; BR carries no data and $0 writes are dropped.
  always_comb begin
    w_ev[0]       = io_bus.wb_en && (io_bus.wb_addr != '0);
    w_ev[1]       = io_bus.mem_we;
    w_ev[2]       = io_bus.br_taken;
    w_act_addr[0] = MEM_AW'(io_bus.wb_addr);
    w_act_data[0] = io_bus.wb_data;
    w_act_addr[1] = io_bus.mem_waddr;
    w_act_data[1] = io_bus.mem_wdata;
    w_act_addr[2] = io_bus.br_target;
    w_act_data[2] = '0;
    w_head_addr[0] = MEM_AW'(r_q_addr[0][r_rp[0]][REG_AW-1:0]);
    w_head_addr[1] = r_q_addr[1][r_rp[1]];
    w_head_addr[2] = r_q_addr[2][r_rp[2]];
    for (int c = 0; c < NCH; c++) begin
      w_head_data[c] = r_q_data[c][r_rp[c]];
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_hit[c]   = w_ev[c] && (r_cnt[c] != '0) &&
                   (w_head_addr[c] == w_act_addr[c]) && (w_head_data[c] == w_act_data[c]);
      w_unexp[c] = w_ev[c] && (r_cnt[c] == '0);
      w_mism[c]  = w_ev[c] && (r_cnt[c] != '0) && !w_hit[c];
    end
    w_err_any = (r_state == S_RUN) && ((w_unexp | w_mism) != '0);
    w_pop     = ((r_state == S_RUN) && !w_err_any) ? w_hit : '0;
    for (int c = 0; c < NCH; c++) begin
      w_left[c] = (r_cnt[c] != QCW'(w_pop[c]));
    end
    w_all_empty = (w_left == '0);
  end

  // Walk from lowest to highest priority so REG overrides MEM overrides BR.
  always_comb begin
    w_err_code = E_NONE;
    w_err_chan = '0;
    w_err_exp  = '0;
    w_err_act  = '0;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_unexp[c] || w_mism[c]) begin
        w_err_code = w_unexp[c] ? E_UNEXP : E_MISMATCH;
        w_err_chan = 2'(c);
        w_err_exp  = w_unexp[c] ? '0 : ((c == 2) ? DATA_W'(w_head_addr[c]) : w_head_data[c]);
        w_err_act  = (c == 2) ? DATA_W'(w_act_addr[c]) : w_act_data[c];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lat_err   = 1'b0;
    w_nxt_code  = w_err_code;
    w_nxt_chan  = w_err_chan;
    w_nxt_exp   = w_err_exp;
    w_nxt_act   = w_err_act;
    case (r_state)
      S_IDLE: begin
        if (io_bus.start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_err_any) begin
          w_state_nxt = S_FAIL;
          w_lat_err   = 1'b1;
        end else if (w_all_empty) begin
          w_state_nxt = S_PASS;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_state_nxt = S_FAIL;
          w_lat_err   = 1'b1;
          w_nxt_code  = E_TIMEOUT;
          w_nxt_chan  = '0;
          w_nxt_exp   = '0;
          w_nxt_act   = '0;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (w_flush) begin
      for (int c = 0; c < NCH; c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
      r_timer     <= '0;
      r_match_cnt <= '0;
      r_err_code  <= E_NONE;
      r_err_chan  <= '0;
      r_err_exp   <= '0;
      r_err_act   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (w_push && (io_bus.exp_chan == 2'(c))) begin
          r_q_addr[c][r_wp[c]] <= io_bus.exp_addr;
          r_q_data[c][r_wp[c]] <= (c == 2) ? '0 : io_bus.exp_data;
          r_wp[c]              <= r_wp[c] + 1'b1;
          r_cnt[c]             <= r_cnt[c] + 1'b1;
        end else if (w_pop[c]) begin
          r_rp[c]  <= r_rp[c] + 1'b1;
          r_cnt[c] <= r_cnt[c] - 1'b1;
        end
      end
      if (r_state == S_IDLE && io_bus.start) r_timer <= '0;
      else if (r_state == S_RUN)             r_timer <= r_timer + 1'b1;
      r_match_cnt <= r_match_cnt + CNT_W'(w_pop[0]) + CNT_W'(w_pop[1]) + CNT_W'(w_pop[2]);
      if (w_lat_err) begin
        r_err_code <= w_nxt_code;
        r_err_chan <= w_nxt_chan;
        r_err_exp  <= w_nxt_exp;
        r_err_act  <= w_nxt_act;
      end
    end
  end

  assign io_bus.done      = (r_state == S_PASS) || (r_state == S_FAIL);
  assign io_bus.pass      = (r_state == S_PASS);
  assign io_bus.fail      = (r_state == S_FAIL);
  assign io_bus.err_code  = r_err_code;
  assign io_bus.err_chan  = r_err_chan;
  assign io_bus.err_exp   = r_err_exp;
  assign io_bus.err_act   = r_err_act;
  assign io_bus.match_cnt = r_match_cnt;
endmodule

// File: doc/commit_checker.md
Name: commit_checker

Overview:
- Synthesizable, parametrised commit-stream checker for the pipeline processor, placed next to the core in the top bench/FPGA wrapper.
- Replaces fixed-cycle register polling: expected register writebacks, data-memory stores and taken branches are preloaded into per-channel queues.
- At run time, each retired event is compared in order against its queue head, independent of pipeline timing. The block reports pass/fail with error diagnostics.

Parameters:
- DATA_W, 32, data width of register, memory and branch-target values.
- REG_AW, 5, register-file index width.
- MEM_AW, 32, data-memory address width.
- DEPTH, 16, entries per expected-event queue (power of two, ≥2).
- TIMEOUT, 500, max cycles in RUN before a timeout failure.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- clear  in  1  synchronous: flush queues, return to IDLE.
- exp_valid  in  1  expected-entry load strobe.
- exp_ready  out  1  load accepted when exp_valid&&exp_ready.
- exp_chan  in  2  0=REG, 1=MEM, 2=BR; 3 is illegal and ignored.
- exp_addr  in  MEM_AW  reg index (low REG_AW bits) / mem address / branch target.
- exp_data  in  DATA_W  expected data (ignored for BR).
- start  in  1  pulse: IDLE->RUN.
- wb_en  in  1  register writeback this cycle.
- wb_addr  in  REG_AW  writeback register index.
- wb_data  in  DATA_W  writeback data.
- mem_we  in  1  data-memory store this cycle.
- mem_waddr  in  MEM_AW  store address.
- mem_wdata  in  DATA_W  store data.
- br_taken  in  1  branch taken (pc_src) this cycle.
- br_target  in  MEM_AW  branch target PC.
- done  out  1  in PASS or FAIL.
- pass  out  1  in PASS.
- fail  out  1  in FAIL.
- err_code  out  3  0 none, 1 mismatch, 2 unexpected event, 3 timeout.
- err_chan  out  2  failing channel (valid when err_code is 1 or 2).
- err_exp  out  DATA_W  expected value at failure (address for BR).
- err_act  out  DATA_W  actual value at failure.
- match_cnt  out  $clog2(3*DEPTH+1)  events matched since start.

Behaviour:
- Reset (rst or clear): state IDLE; all queues empty; done=pass=fail=0; err_*=0; match_cnt=0; timer=0. rst takes priority over every other input.
- States: IDLE, RUN, PASS, FAIL.
- IDLE:
  - exp_ready = 1 iff the queue selected by exp_chan is not full and exp_chan≠3. Writes to a full queue are not accepted.
  - start moves to RUN next cycle and clears the timer. Observed events are ignored in IDLE.
  - A start with all queues empty goes to PASS after one RUN cycle.
- RUN: exp_ready=0. Each cycle, the three channels are checked independently and in parallel.
  - REG: wb_en with wb_addr==0 is ignored, matching core $0 semantics. Otherwise compare {wb_addr,wb_data} with the head's {addr[REG_AW-1:0],data}.
  - MEM: mem_we compares {mem_waddr,mem_wdata} with the head.
  - BR: br_taken compares br_target with the head addr.
  - Event on a channel with an empty queue gives err_code 2.
  - Compare failure gives err_code 1.
  - Match: pop the head; match_cnt increments by the number of channels matched this cycle (0–3).
  - Any error sends state to FAIL next cycle; pops in the failing cycle are discarded. Error priority is REG>MEM>BR; err_exp/err_act latch from the highest-priority failing channel. For err_code 2, err_exp=0.
  - If all queues become empty with no error this cycle, go to PASS.
  - Timer increments each RUN cycle. When timer reaches TIMEOUT-1 and PASS is not reached that cycle, go to FAIL with err_code 3, err_chan=0, err_exp=err_act=0. Pass beats timeout in the same cycle.
- PASS/FAIL: terminal until rst or clear. Outputs are held and observed events are ignored.
- Outputs are registered: decode from state and latched error registers, with no combinational path from observed inputs.
- Queues: circular buffers with pointer wrap at DEPTH and a count of 0..DEPTH; full = count==DEPTH.

Test Plan:
- Load REG {2,0x00050000},{3,0x000D0000},{4,19},{1,0x00120000}, MEM {12,0x000D0000}, BR {0x40}; drive the matching stream including a same-cycle wb+store -> pass=1, match_cnt=6, err_code=0.
- Load REG {6,0x00080000}; drive wb 6/0x00080001 -> fail=1, err_code=1, err_chan=0, err_exp=0x00080000, err_act=0x00080001.
- Empty MEM queue with REG {4,121} loaded; assert mem_we addr 12 -> fail, err_code=2, err_chan=1; a wb write to $0 in the same cycle causes no error.
- Load BR {0x40}, never assert br_taken, TIMEOUT=20 -> fail at the 20th RUN cycle, err_code=3. Separately, last match on the timeout cycle -> pass.
- Load DEPTH+1 REG entries -> exp_ready=0 after DEPTH entries; wrap pointers by running DEPTH, reloading, and rerunning -> pass.
- Assert rst mid-RUN with 3 entries pending -> next cycle IDLE, queues empty, match_cnt=0, done=0; clear in FAIL behaves the same.
